// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: drives PC and pipeline-register write_en/clear so all stages
// advance, stall or flush together; tracks halt and saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_Rs,
  input  logic [3:0]       id_Rt,
  input  logic             id_use_Rs,
  input  logic             id_use_Rt,
  input  logic             ex_MemRead,
  input  logic [3:0]       ex_Rd,
  input  logic             mem_Branch,
  input  logic             mem_taken,
  input  logic             mem_call,
  input  logic             mem_ret,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_run,
  output logic             pc_write_en,
  output logic             pc_redirect,
  output logic             ifid_write_en,
  output logic             ifid_clear,
  output logic             idex_write_en,
  output logic             idex_clear,
  output logic             exmem_write_en,
  output logic             exmem_clear,
  output logic             memwb_write_en,
  output logic             memwb_clear,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_next;
  logic   stall_inc, flush_inc;
  logic   redirect, load_use;

  assign state_dbg = state;

  // Memory handshake: mem_req marks an access in MEM; it completes in the cycle
  // mem_ready is high, and every cycle with mem_req=1 and mem_ready=0 freezes the pipe.
  assign redirect = (mem_Branch & mem_taken) | mem_call | mem_ret;
  assign load_use = ex_MemRead && (ex_Rd != 4'd0) &&
                    ((id_use_Rs && (id_Rs == ex_Rd)) || (id_use_Rt && (id_Rt == ex_Rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_next;
      halted <= (state_next == HALT);
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_next     = state;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    pc_write_en    = 1'b0;
    pc_redirect    = 1'b0;
    ifid_write_en  = 1'b0;
    ifid_clear     = 1'b0;
    idex_write_en  = 1'b0;
    idex_clear     = 1'b0;
    exmem_write_en = 1'b0;
    exmem_clear    = 1'b0;
    memwb_write_en = 1'b0;
    memwb_clear    = 1'b0;
    case (state)
      INIT: begin
        ifid_clear  = 1'b1;
        idex_clear  = 1'b1;
        exmem_clear = 1'b1;
        memwb_clear = 1'b1;
        state_next  = RUN;
      end
      RUN, MEM_WAIT: begin
        if (!wb_run) begin
          state_next = HALT;
        end else if (mem_req && !mem_ready) begin
          state_next = MEM_WAIT;
          stall_inc  = 1'b1;
        end else if (redirect) begin
          // Redirect outranks load-use: the stalled ID instruction is flushed anyway.
          pc_write_en    = 1'b1;
          pc_redirect    = 1'b1;
          ifid_clear     = 1'b1;
          idex_clear     = 1'b1;
          exmem_clear    = 1'b1;
          memwb_write_en = 1'b1;
          flush_inc      = 1'b1;
          state_next     = RUN;
        end else if (load_use) begin
          idex_clear     = 1'b1;
          exmem_write_en = 1'b1;
          memwb_write_en = 1'b1;
          stall_inc      = 1'b1;
          state_next     = RUN;
        end else begin
          pc_write_en    = 1'b1;
          ifid_write_en  = 1'b1;
          idex_write_en  = 1'b1;
          exmem_write_en = 1'b1;
          memwb_write_en = 1'b1;
          state_next     = RUN;
        end
      end
      HALT: state_next = HALT;
      default: state_next = INIT;
    endcase
  end

endmodule
